difftest_commit_sequencer: RTL and testbench
============================================

Name: difftest_commit_sequencer

Overview:
- Sits between the dual-issue commit stage and the difftest bridge.
- Buffers up to two retiring instructions per cycle, plus their store and exception side-info, in an in-order FIFO.
- Replays them to the bridge one per cycle with a running commit index.
- Owns the end-of-simulation drain handshake, so the bridge never sees two commits in one cycle and no commit is lost at halt.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 4.
- IDX_W, 8, width of the commit/store index counter.
- TIMEOUT, 4096, watchdog limit in cycles (optional feature only).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- s0_valid / s1_valid  in  1 each  commit slot valid; s0 is older
- s{0,1}_pc  in  64  instruction PC
- s{0,1}_instr  in  32  instruction word
- s{0,1}_skip  in  1  skip compare (MMIO)
- s{0,1}_wen  in  1  GPR write enable
- s{0,1}_wdest  in  8  GPR index
- s{0,1}_wdata  in  64  GPR write data
- s{0,1}_st_valid  in  8  store byte-valid mask; 0 means not a store
- s{0,1}_st_paddr  in  64  store physical address
- s{0,1}_st_data  in  64  store data
- s{0,1}_excp  in  1  instruction raised a trap
- s{0,1}_cause  in  32  trap cause
- in_ready  out  1  at least 2 free entries and state is RUN
- halt  in  1  pulse: simulation end requested
- out_instrValid  out  1  one commit presented this cycle
- out_index  out  IDX_W  commit index
- out_pc, out_instr, out_skip, out_wen, out_wdest, out_wdata  out  as inputs  head entry fields
- out_storeValid  out  8  head store mask (0 if head is not a store)
- out_storeIndex  out  IDX_W  equals out_index
- out_storePaddr, out_storeData  out  64  head store fields
- out_excp_valid  out  1  head is trapping
- out_cause  out  32  head trap cause
- done  out  1  drain complete
- timeout  out  1  watchdog flag

Behaviour:
- Reset (asynchronous, reset=0):
  - FIFO empty, pointers and count 0, index counter 0, state RUN.
  - All out_* 0, done=0, timeout=0.
  - Applies mid-operation; buffered entries are discarded.
- Enqueue:
  - Enqueue occurs when in_ready=1. Upstream must hold a slot's valid only while in_ready=1; valid with in_ready=0 is ignored (no capture).
  - s0 then s1 are written in order.
  - s1_valid without s0_valid enqueues s1 alone as one entry.
  - Writes take 0, 1 or 2 entries.
- Dequeue:
  - Outputs are registered.
  - An entry written in cycle N appears on out_* in cycle N+1 at the earliest.
  - At most one entry per cycle; head leaves when out_instrValid=1 (the bridge never stalls).
- Count: next = count + enq − deq; simultaneous enqueue and dequeue are legal.
- in_ready = (DEPTH − count ≥ 2) && state==RUN. Full therefore means count ≥ DEPTH−1. Pointers wrap modulo DEPTH.
- Empty FIFO: out_instrValid=0 and all event valids 0; data fields hold their last value.
- Index:
  - Increments after each emitted commit and wraps 2^IDX_W−1 → 0.
  - out_storeIndex equals out_index for the same commit.
- A trapping head emits out_excp_valid=1 with out_instrValid=1 in the same cycle; out_storeValid is forced to 0 for a trapping store.
- FSM:
  - RUN: normal operation. halt=1 → DRAIN; in_ready drops the next cycle. Same-cycle slot inputs are still accepted if in_ready was 1.
  - DRAIN: no enqueue; keep emitting. When count==0 and nothing is emitted this cycle → DONE.
  - DONE: done=1 (held); out_instrValid=0. Left only by reset.
- halt is ignored in DRAIN and DONE.

Optional Feature:
- Macro DIFF_SEQ_TIMEOUT_EN.
- Defined:
  - Cycle counter clears on every emitted commit and counts otherwise while state==RUN.
  - On reaching TIMEOUT, timeout=1, sticky until reset; the sequencer keeps operating.
- Undefined: no counter is instantiated and timeout is tied to 0.

Test Plan:
- Reset mid-stream with 5 entries buffered → all out_* 0 the next cycle; after release the first commit has out_index=0.
- Dual commit pc 0x80000000/0x80000004 in one cycle → emitted on consecutive cycles, index 0 then 1, starting the cycle after capture.
- Sustained dual commits for 8 cycles → in_ready falls at count=7 (DEPTH=8); no entry lost or reordered; indices contiguous.
- 300 single commits → out_index wraps 255→0 and storeIndex tracks it; slot0 store paddr 0x80001000 data 0xdead mask 0x0f → out_storeValid=0x0f with matching index.
- Trapping store, cause 5 → out_excp_valid=1, out_cause=5, out_storeValid=0, same cycle as out_instrValid.
- halt with 3 entries buffered → 3 more commits emitted, then done=1 and in_ready=0; with DIFF_SEQ_TIMEOUT_EN and TIMEOUT=16, 16 idle RUN cycles → timeout=1.

Source files
------------

// File: rtl/difftest_commit_sequencer.sv
// In-order commit sequencer between dual-issue retire and the difftest bridge.
// Optional watchdog enabled by defining DIFF_SEQ_TIMEOUT_EN.
module difftest_commit_sequencer #(
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s0_valid,
    input  logic [63:0]       s0_pc,
    input  logic [31:0]       s0_instr,
    input  logic              s0_skip,
    input  logic              s0_wen,
    input  logic [7:0]        s0_wdest,
    input  logic [63:0]       s0_wdata,
    input  logic [7:0]        s0_st_valid,
    input  logic [63:0]       s0_st_paddr,
    input  logic [63:0]       s0_st_data,
    input  logic              s0_excp,
    input  logic [31:0]       s0_cause,
    input  logic              s1_valid,
    input  logic [63:0]       s1_pc,
    input  logic [31:0]       s1_instr,
    input  logic              s1_skip,
    input  logic              s1_wen,
    input  logic [7:0]        s1_wdest,
    input  logic [63:0]       s1_wdata,
    input  logic [7:0]        s1_st_valid,
    input  logic [63:0]       s1_st_paddr,
    input  logic [63:0]       s1_st_data,
    input  logic              s1_excp,
    input  logic [31:0]       s1_cause,
    output logic              in_ready,
    input  logic              halt,
    output logic              out_instrValid,
    output logic [IDX_W-1:0]  out_index,
    output logic [63:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_skip,
    output logic              out_wen,
    output logic [7:0]        out_wdest,
    output logic [63:0]       out_wdata,
    output logic [7:0]        out_storeValid,
    output logic [IDX_W-1:0]  out_storeIndex,
    output logic [63:0]       out_storePaddr,
    output logic [63:0]       out_storeData,
    output logic              out_excp_valid,
    output logic [31:0]       out_cause,
    output logic              done,
    output logic              timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic [7:0]  st_valid;
        logic [63:0] st_paddr;
        logic [63:0] st_data;
        logic        excp;
        logic [31:0] cause;
    } entry_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state, state_next;
    entry_t             mem [DEPTH];
    entry_t             slot0, slot1, head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic [IDX_W-1:0]   idx_cnt;
    logic               en0, en1, emit;
    logic [1:0]         enq_n;

    assign slot0 = {s0_pc, s0_instr, s0_skip, s0_wen, s0_wdest, s0_wdata,
                    s0_st_valid, s0_st_paddr, s0_st_data, s0_excp, s0_cause};
    assign slot1 = {s1_pc, s1_instr, s1_skip, s1_wen, s1_wdest, s1_wdata,
                    s1_st_valid, s1_st_paddr, s1_st_data, s1_excp, s1_cause};

    assign in_ready   = (count <= CNT_W'(DEPTH - 2)) && (state == RUN);
    assign en0        = s0_valid && in_ready;
    assign en1        = s1_valid && in_ready;
    assign enq_n      = {1'b0, en0} + {1'b0, en1};
    assign emit       = ((count != '0) || en0 || en1) && (state != DONE);
    assign count_next = count + CNT_W'(enq_n) - CNT_W'(emit);
    assign done       = (state == DONE);
    assign out_storeIndex = out_index;

    // An empty FIFO bypasses the oldest incoming slot straight to the output
    // registers; it is still written to memory and skipped by rd_ptr.
    always_comb begin
        head = mem[rd_ptr];
        if (count == '0) begin
            head = en0 ? slot0 : slot1;
        end
    end

    always_ff @(posedge clock) begin
        if (en0) mem[wr_ptr] <= slot0;
        if (en1) mem[wr_ptr + PTR_W'(en0)] <= slot1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt) state_next = DRAIN;
            DRAIN:   if (count == '0 && !emit) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            idx_cnt        <= '0;
            out_instrValid <= 1'b0;
            out_index      <= '0;
            out_pc         <= '0;
            out_instr      <= '0;
            out_skip       <= 1'b0;
            out_wen        <= 1'b0;
            out_wdest      <= '0;
            out_wdata      <= '0;
            out_storeValid <= '0;
            out_storePaddr <= '0;
            out_storeData  <= '0;
            out_excp_valid <= 1'b0;
            out_cause      <= '0;
        end else begin
            wr_ptr         <= wr_ptr + PTR_W'(enq_n);
            rd_ptr         <= rd_ptr + PTR_W'(emit);
            count          <= count_next;
            out_instrValid <= emit;
            out_storeValid <= '0;
            out_excp_valid <= 1'b0;
            if (emit) begin
                idx_cnt        <= idx_cnt + IDX_W'(1);
                out_index      <= idx_cnt;
                out_pc         <= head.pc;
                out_instr      <= head.instr;
                out_skip       <= head.skip;
                out_wen        <= head.wen;
                out_wdest      <= head.wdest;
                out_wdata      <= head.wdata;
                out_storeValid <= head.excp ? 8'h00 : head.st_valid;
                out_storePaddr <= head.st_paddr;
                out_storeData  <= head.st_data;
                out_excp_valid <= head.excp;
                out_cause      <= head.cause;
            end
        end
    end

`ifdef DIFF_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Counts idle RUN cycles; saturates at TIMEOUT and the flag stays sticky.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (emit) begin
            wd_cnt <= '0;
        end else if (state == RUN && wd_cnt != WD_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    // Watchdog compiled out; TIMEOUT is positive so this is a constant 0.
    assign timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// Scoreboard bench for difftest_commit_sequencer: entries pushed on capture,
// popped and compared when the DUT emits a commit.
module tb_difftest_commit_sequencer;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic [7:0]  st_valid;
        logic [63:0] st_paddr;
        logic [63:0] st_data;
        logic        excp;
        logic [31:0] cause;
    } exp_t;

    logic        clock, reset, halt;
    logic        s0_valid, s0_skip, s0_wen, s0_excp;
    logic        s1_valid, s1_skip, s1_wen, s1_excp;
    logic [63:0] s0_pc, s0_wdata, s0_st_paddr, s0_st_data;
    logic [63:0] s1_pc, s1_wdata, s1_st_paddr, s1_st_data;
    logic [31:0] s0_instr, s0_cause, s1_instr, s1_cause;
    logic [7:0]  s0_wdest, s0_st_valid, s1_wdest, s1_st_valid;
    logic        in_ready, out_instrValid, out_skip, out_wen, out_excp_valid, done, timeout;
    logic [7:0]  out_index, out_storeIndex, out_wdest, out_storeValid;
    logic [63:0] out_pc, out_wdata, out_storePaddr, out_storeData;
    logic [31:0] out_instr, out_cause;

    exp_t        sb [$];
    exp_t        mon_e, stim, blank;
    logic [7:0]  exp_idx;
    int          checks, errors, commit_total, base;
    bit          saw_wrap;

    difftest_commit_sequencer #(.DEPTH(8), .IDX_W(8), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_instr(s0_instr), .s0_skip(s0_skip),
        .s0_wen(s0_wen), .s0_wdest(s0_wdest), .s0_wdata(s0_wdata),
        .s0_st_valid(s0_st_valid), .s0_st_paddr(s0_st_paddr), .s0_st_data(s0_st_data),
        .s0_excp(s0_excp), .s0_cause(s0_cause),
        .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_instr(s1_instr), .s1_skip(s1_skip),
        .s1_wen(s1_wen), .s1_wdest(s1_wdest), .s1_wdata(s1_wdata),
        .s1_st_valid(s1_st_valid), .s1_st_paddr(s1_st_paddr), .s1_st_data(s1_st_data),
        .s1_excp(s1_excp), .s1_cause(s1_cause),
        .in_ready(in_ready), .halt(halt),
        .out_instrValid(out_instrValid), .out_index(out_index), .out_pc(out_pc),
        .out_instr(out_instr), .out_skip(out_skip), .out_wen(out_wen),
        .out_wdest(out_wdest), .out_wdata(out_wdata), .out_storeValid(out_storeValid),
        .out_storeIndex(out_storeIndex), .out_storePaddr(out_storePaddr),
        .out_storeData(out_storeData), .out_excp_valid(out_excp_valid),
        .out_cause(out_cause), .done(done), .timeout(timeout)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [63:0] pc);
        exp_t r;
        r.pc       = pc;
        r.instr    = pc[31:0] ^ 32'h0000_0013;
        r.skip     = pc[4];
        r.wen      = pc[2];
        r.wdest    = pc[9:2];
        r.wdata    = ~pc;
        r.st_valid = 8'h00;
        r.st_paddr = 64'h0;
        r.st_data  = 64'h0;
        r.excp     = 1'b0;
        r.cause    = 32'h0;
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive both slots on the falling edge; what the DUT will capture goes to the scoreboard.
    task automatic apply_stimulus(input bit v0, input exp_t e0, input bit v1, input exp_t e1, input bit hlt);
        @(negedge clock);
        s0_valid = v0; s0_pc = e0.pc; s0_instr = e0.instr; s0_skip = e0.skip; s0_wen = e0.wen;
        s0_wdest = e0.wdest; s0_wdata = e0.wdata; s0_st_valid = e0.st_valid;
        s0_st_paddr = e0.st_paddr; s0_st_data = e0.st_data; s0_excp = e0.excp; s0_cause = e0.cause;
        s1_valid = v1; s1_pc = e1.pc; s1_instr = e1.instr; s1_skip = e1.skip; s1_wen = e1.wen;
        s1_wdest = e1.wdest; s1_wdata = e1.wdata; s1_st_valid = e1.st_valid;
        s1_st_paddr = e1.st_paddr; s1_st_data = e1.st_data; s1_excp = e1.excp; s1_cause = e1.cause;
        halt = hlt;
        if (in_ready) begin
            if (v0) sb.push_back(e0);
            if (v1) sb.push_back(e1);
        end
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, blank, 1'b0, blank, 1'b0);
    endtask

    task automatic wait_empty(input string tag);
        apply_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        #1;
        check_output(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (out_instrValid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("pc", out_pc, mon_e.pc);
                    check_output("instr", 64'(out_instr), 64'(mon_e.instr));
                    check_output("skip", 64'(out_skip), 64'(mon_e.skip));
                    check_output("wen", 64'(out_wen), 64'(mon_e.wen));
                    check_output("wdest", 64'(out_wdest), 64'(mon_e.wdest));
                    check_output("wdata", out_wdata, mon_e.wdata);
                    check_output("store_valid", 64'(out_storeValid), mon_e.excp ? 64'd0 : 64'(mon_e.st_valid));
                    check_output("store_paddr", out_storePaddr, mon_e.st_paddr);
                    check_output("store_data", out_storeData, mon_e.st_data);
                    check_output("excp_valid", 64'(out_excp_valid), 64'(mon_e.excp));
                    check_output("cause", 64'(out_cause), 64'(mon_e.cause));
                    check_output("index", 64'(out_index), 64'(exp_idx));
                    check_output("store_index", 64'(out_storeIndex), 64'(exp_idx));
                    if (exp_idx == 8'hff) saw_wrap = 1'b1;
                    exp_idx = exp_idx + 8'd1;
                end
                commit_total++;
            end else begin
                check_output("idle_store_valid", 64'(out_storeValid), 64'd0);
                check_output("idle_excp_valid", 64'(out_excp_valid), 64'd0);
            end
        end
    end

    initial begin
        clock = 1'b0; reset = 1'b0; halt = 1'b0;
        checks = 0; errors = 0; commit_total = 0; exp_idx = 8'd0; saw_wrap = 1'b0;
        blank = mk(64'h0);
        s0_valid = 1'b0; s1_valid = 1'b0;
        apply_idle();
        apply_idle();
        check_output("rst_instr_valid", 64'(out_instrValid), 64'd0);
        check_output("rst_index", 64'(out_index), 64'd0);
        check_output("rst_pc", out_pc, 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_timeout", 64'(timeout), 64'd0);
        reset = 1'b1;
        apply_idle();
        check_output("rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] dual commit latency");
        apply_stimulus(1'b1, mk(64'h8000_0000), 1'b1, mk(64'h8000_0004), 1'b0);
        apply_idle();
        check_output("dual_first_valid", 64'(out_instrValid), 64'd1);
        check_output("dual_first_pc", out_pc, 64'h8000_0000);
        check_output("dual_first_index", 64'(out_index), 64'd0);
        apply_idle();
        check_output("dual_second_pc", out_pc, 64'h8000_0004);
        check_output("dual_second_index", 64'(out_index), 64'd1);
        apply_idle();
        check_output("empty_valid", 64'(out_instrValid), 64'd0);
        check_output("empty_hold_pc", out_pc, 64'h8000_0004);

        $display("[TB] sustained dual commits");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, mk(64'h8000_1000 + 64'(16 * i)), 1'b1,
                           mk(64'h8000_1008 + 64'(16 * i)), 1'b0);
            check_output($sformatf("sustain_ready_%0d", i), 64'(in_ready), (i < 7) ? 64'd1 : 64'd0);
        end
        wait_empty("sustain_drain");

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, mk(64'h8000_2000 + 64'(16 * i)), 1'b1,
                           mk(64'h8000_2008 + 64'(16 * i)), 1'b0);
        apply_idle();
        #2 reset = 1'b0;
        #1;
        sb.delete();
        exp_idx = 8'd0;
        check_output("midrst_valid", 64'(out_instrValid), 64'd0);
        check_output("midrst_pc", out_pc, 64'd0);
        check_output("midrst_index", 64'(out_index), 64'd0);
        check_output("midrst_wdata", out_wdata, 64'd0);
        apply_idle();
        reset = 1'b1;
        apply_stimulus(1'b1, mk(64'h8000_3000), 1'b1, mk(64'h8000_3004), 1'b0);
        apply_idle();
        check_output("post_rst_pc", out_pc, 64'h8000_3000);
        check_output("post_rst_index", 64'(out_index), 64'd0);
        wait_empty("post_rst_drain");

        $display("[TB] single commits with index wrap, store and trap");
        for (int i = 0; i < 300; i++) begin
            stim = mk(64'h8001_0000 + 64'(4 * i));
            if (i == 100) begin
                stim.st_valid = 8'h0f; stim.st_paddr = 64'h8000_1000; stim.st_data = 64'hdead;
            end
            if (i == 150) begin
                stim.st_valid = 8'hff; stim.st_paddr = 64'h8000_2000; stim.st_data = 64'hbeef;
                stim.excp = 1'b1; stim.cause = 32'd5;
            end
            apply_stimulus(1'b1, stim, 1'b0, blank, 1'b0);
            if (i == 101) begin
                check_output("store_mask", 64'(out_storeValid), 64'h0f);
                check_output("store_addr", out_storePaddr, 64'h8000_1000);
            end
            if (i == 151) begin
                check_output("trap_instr_valid", 64'(out_instrValid), 64'd1);
                check_output("trap_excp", 64'(out_excp_valid), 64'd1);
                check_output("trap_cause", 64'(out_cause), 64'd5);
                check_output("trap_store_masked", 64'(out_storeValid), 64'd0);
            end
        end
        wait_empty("single_drain");
        check_output("index_wrapped", 64'(saw_wrap), 64'd1);

        $display("[TB] halt drain");
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, mk(64'h8000_4000 + 64'(16 * i)), 1'b1,
                           mk(64'h8000_4008 + 64'(16 * i)), 1'b0);
        apply_stimulus(1'b0, blank, 1'b0, blank, 1'b1);
        #1;
        base = commit_total;
        check_output("ready_in_halt_cycle", 64'(in_ready), 64'd1);
        apply_idle();
        check_output("ready_after_halt", 64'(in_ready), 64'd0);
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clock);
        #1;
        check_output("halt_done", 64'(done), 64'd1);
        check_output("halt_commits", 64'(commit_total - base), 64'd3);
        check_output("halt_ready", 64'(in_ready), 64'd0);
        check_output("halt_sb_empty", 64'(sb.size()), 64'd0);
        apply_stimulus(1'b1, mk(64'h8000_5000), 1'b1, mk(64'h8000_5004), 1'b1);
        apply_idle();
        apply_idle();
        check_output("done_held", 64'(done), 64'd1);
        check_output("done_no_commit", 64'(out_instrValid), 64'd0);

        $display("[TB] watchdog");
        #2 reset = 1'b0;
        apply_idle();
        reset = 1'b1;
        check_output("done_cleared", 64'(done), 64'd0);
        repeat (20) apply_idle();
`ifdef DIFF_SEQ_TIMEOUT_EN
        check_output("timeout_set", 64'(timeout), 64'd1);
`else
        check_output("timeout_tied", 64'(timeout), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
